// File: rtl/ballot_pkg.sv
// Shared definitions for the ballot session controller: FSM state
// encoding, candidate count and a helper for sizing the session timer.
package ballot_pkg;

    localparam int NUM_CAND = 4;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        IDLE    = 3'd1,
        ARMED   = 3'd2,
        COMMIT  = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    // The timer is loaded with (cycles - 1), so clog2 of the larger
    // duration is always wide enough; never return a zero width.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m <= 2) begin
            return 1;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/session_timer.sv
// Loadable down-counter shared by the voter timeout and the post-commit
// lockout. It holds at zero, and o_done flags the zero count.
module session_timer #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/ballot_session_controller.sv
// Voting-booth session controller. An officer opens the poll and
// authorises one voter at a time. A single button press is committed as a
// one-cycle one-hot pulse to the logger. Simultaneous presses spoil the
// attempt but keep the session armed. An idle voter is timed out, and a
// lockout window after each commit ignores all buttons.
module ballot_session_controller
    import ballot_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                poll_open,
    input  logic                voter_auth,
    input  logic [NUM_CAND:1]   valid_vote,
    output logic [NUM_CAND:1]   cast_vote,
    output logic                ready,
    output logic [CNT_W-1:0]    voters_served,
    output logic [CNT_W-1:0]    spoilt_count,
    output logic [CNT_W-1:0]    timeout_count,
    output logic [2:0]          state_o
);

    localparam int TMR_W = timer_width(TIMEOUT_CYCLES, LOCKOUT_CYCLES);
    // A duration of N cycles is realised by loading N-1 and leaving on zero.
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                r_rst_sync;
    logic                w_rst_n;
    state_t              r_state;
    state_t              w_next;
    logic [NUM_CAND:1]   r_vote;
    logic [CNT_W-1:0]    r_served;
    logic [CNT_W-1:0]    r_spoilt;
    logic [CNT_W-1:0]    r_timeout;
    logic                w_single;
    logic                w_multi;
    logic                w_accept;
    logic                w_spoil;
    logic                w_timeout;
    logic                w_commit;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_val;
    logic                w_tmr_done;

    // Reset asserts immediately but releases only after one clock edge.
    // The first state update therefore lands on the second edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_sync <= 1'b1;
        end
    end

    assign w_rst_n = r_rst_sync;

    // Press classification: exactly one button, or a spoiling multi-press.
    assign w_single = $onehot(valid_vote);
    assign w_multi  = (valid_vote != '0) && !w_single;

    session_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .i_clk      (clock),
        .i_rst_n    (w_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // State register.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= CLOSED;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, event strobes and outputs. Closing the poll wins over
    // everything except the commit pulse already being driven.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_spoil    = 1'b0;
        w_timeout  = 1'b0;
        w_commit   = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = TIMEOUT_LOAD;
        case (r_state)
            CLOSED: begin
                if (poll_open) begin
                    w_next = IDLE;
                end
            end
            IDLE: begin
                if (!poll_open) begin
                    w_next = CLOSED;
                end else if (voter_auth) begin
                    w_next     = ARMED;
                    w_tmr_load = 1'b1;
                end
            end
            ARMED: begin
                if (!poll_open) begin
                    w_next = CLOSED;
                end else if (w_single) begin
                    w_next   = COMMIT;
                    w_accept = 1'b1;
                end else if (w_multi) begin
                    w_spoil    = 1'b1;
                    w_tmr_load = 1'b1;
                end else if (w_tmr_done) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
                if (!poll_open) begin
                    w_next = CLOSED;
                end else begin
                    w_next     = LOCKOUT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = LOCKOUT_LOAD;
                end
            end
            LOCKOUT: begin
                if (!poll_open) begin
                    w_next = CLOSED;
                end else if (w_tmr_done) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = CLOSED;
            end
        endcase
        ready     = (r_state == ARMED);
        cast_vote = w_commit ? r_vote : '0;
    end

    // Hold the accepted one-hot press until the commit cycle.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vote <= '0;
        end else if (w_accept) begin
            r_vote <= valid_vote;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_served  <= '0;
            r_spoilt  <= '0;
            r_timeout <= '0;
        end else begin
            if (w_commit) begin
                r_served <= sat_inc(r_served);
            end
            if (w_spoil) begin
                r_spoilt <= sat_inc(r_spoilt);
            end
            if (w_timeout) begin
                r_timeout <= sat_inc(r_timeout);
            end
        end
    end

    assign voters_served = r_served;
    assign spoilt_count  = r_spoilt;
    assign timeout_count = r_timeout;
    assign state_o       = r_state;

endmodule

// File: doc/ballot_session_controller.md
BALLOT_SESSION_CONTROLLER -- requirements
Module: ballot_session_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, the maximum number of cycles an authorised voter may take before the session is abandoned.
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 16, the number of post-commit cycles during which all buttons are ignored.
REQ-003 SHALL have parameter CNT_W, default 8, the width of every statistics counter.
REQ-004 SHALL have port clock, input, 1, the sole clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset, input, 1, the asynchronous active-low reset (asserted at 0).
REQ-006 SHALL have port poll_open, input, 1, the officer level: 1 means polling is open.
REQ-007 SHALL have port voter_auth, input, 1, a one-cycle officer pulse that authorises exactly one ballot.
REQ-008 SHALL have port valid_vote, input, [4:1], the debounced one-cycle button pulses, one bit per candidate.
REQ-009 SHALL have port cast_vote, output, [4:1], a one-hot one-cycle pulse to the vote logger.
REQ-010 SHALL have port ready, output, 1, asserted high while an authorised voter may press a button.
REQ-011 SHALL have port voters_served, output, CNT_W, the count of committed ballots.
REQ-012 SHALL have port spoilt_count, output, CNT_W, the count of multi-press rejections.
REQ-013 SHALL have port timeout_count, output, CNT_W, the count of abandoned sessions.
REQ-014 SHALL have port state_o, output, 3, the current FSM state for display and debug.

Function
REQ-015 SHALL implement FSM states CLOSED, IDLE, ARMED, COMMIT and LOCKOUT.
REQ-016 SHALL transition CLOSED->IDLE when poll_open=1, and SHALL move from any state to CLOSED when poll_open=0; an in-flight ARMED session is discarded without a vote or counter update, but COMMIT SHALL still emit its pulse that cycle.
REQ-017 SHALL transition IDLE->ARMED on voter_auth=1; voter_auth SHALL be ignored in every other state.
REQ-018 SHALL assert ready combinationally from state only, equal to 1 exactly when the state is ARMED.
REQ-019 In ARMED, when exactly one valid_vote bit is set, the FSM SHALL latch that bit and transition to COMMIT on the next cycle.
REQ-020 In ARMED, when two or more valid_vote bits are set in the same cycle, the FSM SHALL increment spoilt_count, remain ARMED, and restart the timeout.
REQ-021 In ARMED, the FSM SHALL transition to IDLE and increment timeout_count when TIMEOUT_CYCLES cycles elapse with no accepted press.
REQ-022 COMMIT SHALL last exactly one cycle, drive cast_vote equal to the latched one-hot value, increment voters_served, and move to LOCKOUT.
REQ-023 cast_vote SHALL be 0 in every state other than COMMIT; press-to-cast_vote latency is exactly 1 cycle.
REQ-024 LOCKOUT SHALL last LOCKOUT_CYCLES cycles, ignore valid_vote and voter_auth, and then move to IDLE.
REQ-025 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 valid_vote pulses outside ARMED SHALL have no effect.
REQ-027 At most one cast_vote pulse SHALL be produced per voter_auth.

Reset
REQ-028 While reset=0, the state SHALL be CLOSED, cast_vote=0, ready=0, all counters=0 and the timer=0, independent of clock.
REQ-029 Reset deassertion SHALL be synchronised so that the first state update occurs on the second clock edge after release.
REQ-030 A reset asserted during ARMED or COMMIT SHALL suppress any pending cast_vote.

Structure
REQ-031 The state encoding (3-bit enum: CLOSED=0, IDLE=1, ARMED=2, COMMIT=3, LOCKOUT=4) and the NUM_CAND=4 constant SHALL live in the shared package ballot_pkg.
REQ-032 One sub-module, session_timer, SHALL provide a loadable down-counter with a done flag, shared by the timeout and lockout functions, sized to clog2 of the maximum of the two parameters.
REQ-033 The one-hot and multi-bit press detection SHALL be combinational inside ballot_session_controller.

Verification
REQ-034 Scenario: poll_open=1, voter_auth pulse, valid_vote=4'b0100 two cycles later -> cast_vote=4'b0100 for exactly 1 cycle, voters_served=1, then 16 LOCKOUT cycles, then IDLE.
REQ-035 Scenario: in ARMED, valid_vote=4'b0011 -> spoilt_count=1, no cast_vote, ready stays 1; a later 4'b1000 -> cast_vote=4'b1000.
REQ-036 Scenario: voter_auth with no press for 1000 cycles -> timeout_count=1, state IDLE, cast_vote never asserted; a press at cycle 1001 is ignored.
REQ-037 Scenario: second voter_auth and presses during LOCKOUT or COMMIT -> ignored, voters_served increments by exactly 1.
REQ-038 Scenario: poll_open drops while ARMED -> CLOSED next cycle, no counter change; reset=0 mid-ARMED -> all outputs 0 asynchronously.
REQ-039 Scenario: with CNT_W=2, 5 committed ballots -> voters_served=3 (saturated).
